// File: rtl/adat_rx_sync_supervisor.sv
// ADAT receiver supervisor: resets the receiver, qualifies lock and frame mode, gates frame strobes.
// Statistics counters exist only when ADAT_RX_SUPERVISOR_STATS_EN is defined; otherwise the ports read 0.
module adat_rx_sync_supervisor #(
    parameter int unsigned CLK_FREQ            = 100_000_000,
    parameter int unsigned RESET_HOLD_CYC      = 16,
    parameter int unsigned LOCK_FRAMES         = 4,
    parameter int unsigned ACQUIRE_TIMEOUT_CYC = 65536,
    parameter int unsigned STALL_TIMEOUT_CYC   = 4096,
    parameter int unsigned MAX_RETRIES         = 7
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_restart,
    input  logic        i_rx_locked,
    input  logic        i_rx_valid,
    input  logic [3:0]  i_rx_user,
    input  logic [3:0]  i_rx_valid_channels,
    output logic        o_rx_reset,
    output logic        o_valid,
    output logic        o_stream_en,
    output logic        o_smux2,
    output logic [2:0]  o_state,
    output logic [3:0]  o_retries,
    output logic        o_fault,
    output logic [31:0] o_frame_count,
    output logic [15:0] o_unlock_count
);
    typedef enum logic [2:0] {
        RESET_RX = 3'd0,
        ACQUIRE  = 3'd1,
        RUN      = 3'd2,
        FAULT    = 3'd3
    } state_t;

    localparam int unsigned TMR_MAX_A = (RESET_HOLD_CYC > STALL_TIMEOUT_CYC) ? RESET_HOLD_CYC : STALL_TIMEOUT_CYC;
    localparam int unsigned TMR_MAX   = (ACQUIRE_TIMEOUT_CYC > TMR_MAX_A) ? ACQUIRE_TIMEOUT_CYC : TMR_MAX_A;
    // One timer serves the hold, acquire and stall intervals, since only one is live per state.
    localparam int unsigned TMR_W     = (CLK_FREQ > 0) ? $clog2(TMR_MAX + 1) : 32;

    localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(RESET_HOLD_CYC - 1);
    localparam logic [TMR_W-1:0] ACQ_LAST   = TMR_W'(ACQUIRE_TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] STALL_LAST = TMR_W'(STALL_TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_SAT    = TMR_W'(TMR_MAX);
    localparam logic [3:0]       LOCK_LAST  = 4'(LOCK_FRAMES - 1);
    localparam logic [3:0]       RETRY_LIM  = 4'(MAX_RETRIES);

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic [3:0]       good_cnt;
    logic             mode_ref;

    logic             frame_mode;
    logic             chan_ok;
    logic             qualifies;
    logic [TMR_W-1:0] timer_next;
    logic [3:0]       retries_next;
    logic             unused_user_bits;

    always_comb begin
        frame_mode   = i_rx_user[2];
        chan_ok      = frame_mode ? (i_rx_valid_channels == 4'd4) : (i_rx_valid_channels == 4'd8);
        qualifies    = i_rx_valid && i_rx_locked && chan_ok &&
                       ((good_cnt == '0) || (frame_mode == mode_ref));
        timer_next   = (timer == TMR_SAT) ? timer : timer + 1'b1;
        retries_next = (o_retries == '1) ? o_retries : o_retries + 4'd1;
    end

    assign unused_user_bits = ^{i_rx_user[3], i_rx_user[1:0]};
    assign o_state          = state;

`ifdef ADAT_RX_SUPERVISOR_STATS_EN
    logic [31:0] frame_cnt;
    logic [15:0] unlock_cnt;
    assign o_frame_count  = frame_cnt;
    assign o_unlock_count = unlock_cnt;
`else
    assign o_frame_count  = '0;
    assign o_unlock_count = '0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= RESET_RX;
            timer       <= '0;
            good_cnt    <= '0;
            mode_ref    <= 1'b0;
            o_rx_reset  <= 1'b1;
            o_valid     <= 1'b0;
            o_stream_en <= 1'b0;
            o_smux2     <= 1'b0;
            o_retries   <= '0;
            o_fault     <= 1'b0;
`ifdef ADAT_RX_SUPERVISOR_STATS_EN
            frame_cnt   <= '0;
            unlock_cnt  <= '0;
`endif
        end else begin
            o_valid <= 1'b0;
            if (i_restart) begin
`ifdef ADAT_RX_SUPERVISOR_STATS_EN
                if (state == RUN && unlock_cnt != '1) unlock_cnt <= unlock_cnt + 16'd1;
`endif
                state       <= RESET_RX;
                timer       <= '0;
                good_cnt    <= '0;
                o_rx_reset  <= 1'b1;
                o_stream_en <= 1'b0;
                o_fault     <= 1'b0;
                o_retries   <= '0;
            end else begin
                unique case (state)
                    RESET_RX: begin
                        if (timer == HOLD_LAST) begin
                            state      <= ACQUIRE;
                            timer      <= '0;
                            good_cnt   <= '0;
                            o_rx_reset <= 1'b0;
                        end else begin
                            timer <= timer_next;
                        end
                    end
                    ACQUIRE: begin
                        if (qualifies && good_cnt == LOCK_LAST) begin
                            state       <= RUN;
                            timer       <= '0;
                            o_stream_en <= 1'b1;
                            o_smux2     <= frame_mode;
                            o_retries   <= '0;
                        end else if (timer == ACQ_LAST) begin
                            timer     <= '0;
                            o_retries <= retries_next;
                            if (o_retries >= RETRY_LIM) begin
                                state   <= FAULT;
                                o_fault <= 1'b1;
                            end else begin
                                state      <= RESET_RX;
                                o_rx_reset <= 1'b1;
                            end
                        end else begin
                            timer <= timer_next;
                            if (qualifies) begin
                                good_cnt <= good_cnt + 4'd1;
                                if (good_cnt == '0) mode_ref <= frame_mode;
                            end else if (i_rx_valid) begin
                                good_cnt <= '0;
                            end
                        end
                    end
                    RUN: begin
                        if (!i_rx_locked || (!i_rx_valid && timer == STALL_LAST)) begin
`ifdef ADAT_RX_SUPERVISOR_STATS_EN
                            if (unlock_cnt != '1) unlock_cnt <= unlock_cnt + 16'd1;
`endif
                            state       <= RESET_RX;
                            timer       <= '0;
                            good_cnt    <= '0;
                            o_rx_reset  <= 1'b1;
                            o_stream_en <= 1'b0;
                        end else if (i_rx_valid && frame_mode != o_smux2) begin
                            // Mode change re-qualifies without disturbing the receiver.
                            state       <= ACQUIRE;
                            timer       <= '0;
                            good_cnt    <= '0;
                            o_stream_en <= 1'b0;
                        end else begin
                            o_valid <= i_rx_valid;
                            timer   <= i_rx_valid ? '0 : timer_next;
`ifdef ADAT_RX_SUPERVISOR_STATS_EN
                            if (i_rx_valid) frame_cnt <= frame_cnt + 32'd1;
`endif
                        end
                    end
                    FAULT: begin
                        o_fault    <= 1'b1;
                        o_rx_reset <= 1'b0;
                    end
                    default: begin
                        state      <= RESET_RX;
                        timer      <= '0;
                        o_rx_reset <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_adat_rx_sync_supervisor.sv
// Randomized bench for adat_rx_sync_supervisor against a timestamp/queue reference model.
// Counter expectations follow ADAT_RX_SUPERVISOR_STATS_EN when the bench is built with it.
module tb_adat_rx_sync_supervisor;
    localparam int unsigned HOLD      = 16;
    localparam int unsigned LOCK      = 4;
    localparam int unsigned ACQ_TO    = 1024;
    localparam int unsigned STALL_TO  = 256;
    localparam int unsigned MAX_RETRY = 7;
    localparam int M_RST = 0, M_ACQ = 1, M_RUN = 2, M_FAULT = 3;

    logic        i_clk = 1'b0;
    logic        i_rst, i_restart, i_rx_locked, i_rx_valid;
    logic [3:0]  i_rx_user, i_rx_valid_channels;
    logic        o_rx_reset, o_valid, o_stream_en, o_smux2, o_fault;
    logic [2:0]  o_state;
    logic [3:0]  o_retries;
    logic [31:0] o_frame_count;
    logic [15:0] o_unlock_count;

    always #5 i_clk = ~i_clk;

    adat_rx_sync_supervisor #(
        .CLK_FREQ(100_000_000), .RESET_HOLD_CYC(HOLD), .LOCK_FRAMES(LOCK),
        .ACQUIRE_TIMEOUT_CYC(ACQ_TO), .STALL_TIMEOUT_CYC(STALL_TO), .MAX_RETRIES(MAX_RETRY)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_restart(i_restart), .i_rx_locked(i_rx_locked),
        .i_rx_valid(i_rx_valid), .i_rx_user(i_rx_user), .i_rx_valid_channels(i_rx_valid_channels),
        .o_rx_reset(o_rx_reset), .o_valid(o_valid), .o_stream_en(o_stream_en), .o_smux2(o_smux2),
        .o_state(o_state), .o_retries(o_retries), .o_fault(o_fault),
        .o_frame_count(o_frame_count), .o_unlock_count(o_unlock_count)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: state plus entry/strobe timestamps and the modes of qualifying frames.
    int          m_state;
    longint      cyc, t_entry, last_strobe;
    bit          q_modes[$];
    int          m_retries;
    bit          m_smux2, m_valid;
    int unsigned m_frames, m_unlocks;

    function automatic void m_enter(input int s);
        m_state     = s;
        t_entry     = cyc;
        last_strobe = cyc;
        q_modes.delete();
    endfunction

    function automatic void m_reset();
        cyc = 0;
        m_enter(M_RST);
        m_retries = 0; m_smux2 = 0; m_valid = 0; m_frames = 0; m_unlocks = 0;
    endfunction

    function automatic void m_unlock();
        if (m_unlocks < 16'hFFFF) m_unlocks++;
    endfunction

    function automatic void m_edge();
        bit mode  = i_rx_user[2];
        bit ch_ok = mode ? (i_rx_valid_channels == 4'd4) : (i_rx_valid_channels == 4'd8);
        bit qual  = i_rx_valid && i_rx_locked && ch_ok && (q_modes.size() == 0 || q_modes[0] == mode);
        m_valid = 0;
        if (i_restart) begin
            if (m_state == M_RUN) m_unlock();
            m_retries = 0;
            m_enter(M_RST);
            return;
        end
        case (m_state)
            M_RST: if (cyc - t_entry == HOLD) m_enter(M_ACQ);
            M_ACQ: begin
                if (qual && q_modes.size() + 1 == LOCK) begin
                    m_smux2 = mode; m_retries = 0; m_enter(M_RUN);
                end else if (cyc - t_entry == ACQ_TO) begin
                    if (m_retries >= MAX_RETRY) m_enter(M_FAULT); else m_enter(M_RST);
                    m_retries = (m_retries < 15) ? m_retries + 1 : 15;
                end else if (qual) q_modes.push_back(mode);
                else if (i_rx_valid) q_modes.delete();
            end
            M_RUN: begin
                if (!i_rx_locked || (!i_rx_valid && cyc - last_strobe == STALL_TO)) begin
                    m_unlock(); m_enter(M_RST);
                end else if (i_rx_valid && mode != m_smux2) m_enter(M_ACQ);
                else if (i_rx_valid) begin
                    m_valid = 1; m_frames++; last_strobe = cyc;
                end
            end
            default: ;
        endcase
    endfunction

    function automatic logic [11:0] exp_vec();
        return {3'(m_state), m_state == M_RST, m_valid, m_state == M_RUN, m_smux2,
                4'(m_retries), m_state == M_FAULT};
    endfunction

    function automatic logic [11:0] obs_vec();
        return {o_state, o_rx_reset, o_valid, o_stream_en, o_smux2, o_retries, o_fault};
    endfunction

    function automatic logic [31:0] exp_frames();
`ifdef ADAT_RX_SUPERVISOR_STATS_EN
        return m_frames;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [15:0] exp_unlocks();
`ifdef ADAT_RX_SUPERVISOR_STATS_EN
        return 16'(m_unlocks);
`else
        return 16'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge i_clk);
        cyc++;
        m_edge();
        @(negedge i_clk);
        check("outputs", 64'(obs_vec()), 64'(exp_vec()));
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_frames"}, 64'(o_frame_count), 64'(exp_frames()));
        check({tag, "_unlocks"}, 64'(o_unlock_count), 64'(exp_unlocks()));
    endtask

    task automatic send_frame(input bit smux, input bit bad_ch);
        int unsigned gap = $urandom_range(20, 60);
        i_rx_valid = 1'b0;
        repeat (gap) tick();
        i_rx_user           = {1'($urandom), smux, 2'($urandom)};
        i_rx_valid_channels = bad_ch ? 4'd6 : (smux ? 4'd4 : 4'd8);
        i_rx_valid          = 1'b1;
        tick();
        i_rx_valid = 1'b0;
    endtask

    task automatic send_frames(input int unsigned n, input bit smux);
        for (int unsigned k = 0; k < n; k++) send_frame(smux, 1'b0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        bit          soak_mode;
        i_rst = 1'b1; i_restart = 1'b0; i_rx_locked = 1'b0; i_rx_valid = 1'b0;
        i_rx_user = 4'h0; i_rx_valid_channels = 4'd0;
        repeat (2) @(negedge i_clk);
        m_reset();
        i_rst = 1'b0;
        check("reset_values", 64'(obs_vec()), 64'(12'b000_1_0_0_0_0000_0));
        check_counters("reset");

        // Normal-mode lock
        i_rx_locked = 1'b1;
        send_frames(6, 1'b0);
        check("t1_run", 64'(o_state), 64'd2);
        check("t1_smux2", 64'(o_smux2), 64'd0);

        // S/MUX2 re-qualification, then a normal frame drops back to ACQUIRE
        send_frames(6, 1'b1);
        check("t2_smux2", 64'(o_smux2), 64'd1);
        send_frame(1'b0, 1'b0);
        check("t2_acquire", 64'(o_state), 64'd1);
        check("t2_no_rx_reset", 64'(o_rx_reset), 64'd0);
        send_frames(5, 1'b1);

        // Single-cycle lock loss
        repeat (5) tick();
        i_rx_locked = 1'b0; tick(); i_rx_locked = 1'b1;
        check("t3_reset_rx", 64'(o_state), 64'd0);
        check("t3_stream_en", 64'(o_stream_en), 64'd0);
        check_counters("t3");
        send_frames(6, 1'b1);

        // Stalled stream
        n = 0;
        do begin tick(); n++; end while (o_state != 3'd0 && n < 2 * STALL_TO);
        check("t4_stall_delay", 64'(n), 64'(STALL_TO));
        send_frames(6, 1'b0);
        check("t4_run_again", 64'(o_state), 64'd2);

        // Receiver never locks
        i_rx_locked = 1'b0;
        n = 0;
        while (o_fault !== 1'b1 && n < 12000) begin
            i_rx_valid = ($urandom_range(0, 29) == 0);
            i_rx_user  = 4'($urandom);
            tick(); n++;
        end
        i_rx_valid = 1'b0;
        check("t5_fault", 64'(o_fault), 64'd1);
        check("t5_retries", 64'(o_retries), 64'(MAX_RETRY + 1));
        check("t5_rx_reset", 64'(o_rx_reset), 64'd0);
        i_rx_locked = 1'b1;
        send_frames(6, 1'b0);
        check("t5_fault_holds", 64'(o_state), 64'd3);
        i_restart = 1'b1; tick(); i_restart = 1'b0;
        check("t5_restart_state", 64'(o_state), 64'd0);
        check("t5_restart_retries", 64'(o_retries), 64'd0);

        // Restart wins over a simultaneous lock loss in RUN
        send_frames(6, 1'b0);
        i_restart = 1'b1; i_rx_locked = 1'b0; tick();
        i_restart = 1'b0; i_rx_locked = 1'b1;
        check("restart_wins", 64'(o_state), 64'd0);
        check_counters("restart");

        // Asynchronous reset with a strobe pending
        send_frames(6, 1'b0);
        check("t6_valid_pending", 64'(o_valid), 64'(m_valid));
        #2 i_rst = 1'b1;
        #1 m_reset();
        check("t6_async_reset", 64'(obs_vec()), 64'(exp_vec()));
        check_counters("t6");
        @(negedge i_clk);
        i_rst = 1'b0;
        send_frames(6, 1'b0);

        // Random soak
        soak_mode = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            i_rx_valid  = ($urandom_range(0, 24) == 0);
            i_rx_locked = ($urandom_range(0, 299) != 0);
            if (i_rx_valid && $urandom_range(0, 39) == 0) soak_mode = ~soak_mode;
            i_rx_user           = {1'($urandom), soak_mode, 2'($urandom)};
            i_rx_valid_channels = ($urandom_range(0, 19) == 0) ? 4'($urandom) : (soak_mode ? 4'd4 : 4'd8);
            i_restart           = ($urandom_range(0, 1499) == 0);
            tick();
        end
        i_restart = 1'b0; i_rx_valid = 1'b0;
        tick();
        check_counters("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
